// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_arbiter_pkg
//  Purpose  : Shared constants for the data-memory arbiter: FSM state codes,
//             default address/data widths and wait-counter sizing helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package data_mem_arbiter_pkg;

  // Default widths and timeout used by the top-level parameters
  localparam int unsigned c_aw_default      = 32;
  localparam int unsigned c_dw_default      = 32;
  localparam int unsigned c_timeout_default = 64;

  // Transaction FSM encoding
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_resp  = 2'd3;

  // Width of a counter that must be able to hold the value tmo.
  // A zero timeout still gets a 1-bit counter so the declaration stays legal.
  function automatic int unsigned f_cnt_width(input int unsigned tmo);
    return (tmo < 2) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_arbiter_rr_arbiter2
//  Purpose  : Two-way round-robin arbiter. On a tie the requester that did
//             not win last time is chosen; a sole requester always wins.
//             The last-grant record updates only when update_i is high and
//             some request is present.
//  Ports    : clk, rst_n      clock / async active-low reset
//             req_i[1:0]      request vector (bit n = requester n)
//             update_i        commit the current grant as "last grant"
//             any_o           at least one request present
//             gnt_o           index of the winning requester
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_arbiter_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       any_o,
  output logic       gnt_o
);

  logic last_q;

  always_comb begin
    any_o = |req_i;
    if (&req_i) begin
      gnt_o = ~last_q;
    end else begin
      // Sole requester (or nobody, in which case the value is ignored)
      gnt_o = req_i[1];
    end
  end

  // Reset to requester 1 so requester 0 wins the very first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (update_i && any_o) begin
      last_q <= gnt_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_arbiter
//  Purpose  : Shares a single-port, variable-latency data memory between a
//             CPU load/store port (rq0) and a DMA/debug port (rq1). One
//             transaction at a time, round-robin, IDLE->ISSUE->WAIT->RESP.
//             All outputs are registered.
//  Ports    : clk, rst_n                 clock / async active-low reset
//             rqN_valid_i/we_i/addr_i/wdata_i   request, held until ack
//             rqN_ack_o                  one-cycle completion pulse
//             rqN_rdata_o                read data, valid with ack, else 0
//             mem_we_o/addr_o/wdata_o    memory command
//             mem_rdata_i/mem_ready_i    memory response
//             timeout_err_o              sticky: a wait exceeded TIMEOUT
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = c_aw_default,
  parameter int unsigned DW      = c_dw_default,
  parameter int unsigned TIMEOUT = c_timeout_default
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rq0_valid_i,
  input  logic          rq0_we_i,
  input  logic [AW-1:0] rq0_addr_i,
  input  logic [DW-1:0] rq0_wdata_i,
  output logic          rq0_ack_o,
  output logic [DW-1:0] rq0_rdata_o,
  input  logic          rq1_valid_i,
  input  logic          rq1_we_i,
  input  logic [AW-1:0] rq1_addr_i,
  input  logic [DW-1:0] rq1_wdata_i,
  output logic          rq1_ack_o,
  output logic [DW-1:0] rq1_rdata_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i,
  output logic          timeout_err_o
);

  localparam int unsigned     c_cw      = f_cnt_width(TIMEOUT);
  localparam logic [c_cw-1:0] c_tmo_cnt = c_cw'(TIMEOUT);

  logic [1:0]      state_q,     state_d;
  logic            gnt_q,       gnt_d;        // requester owning the transaction
  logic            we_q,        we_d;         // latched direction
  logic            mem_we_q,    mem_we_d;
  logic [AW-1:0]   mem_addr_q,  mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [c_cw-1:0] wait_cnt_q,  wait_cnt_d;
  logic            ack0_q,      ack0_d;
  logic            ack1_q,      ack1_d;
  logic [DW-1:0]   rdata0_q,    rdata0_d;
  logic [DW-1:0]   rdata1_q,    rdata1_d;
  logic            terr_q,      terr_d;

  logic            arb_any;
  logic            arb_gnt;
  logic            tmo_hit;

  data_mem_arbiter_rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({rq1_valid_i, rq0_valid_i}),
    .update_i (state_q == c_st_idle),
    .any_o    (arb_any),
    .gnt_o    (arb_gnt)
  );

  assign tmo_hit = (TIMEOUT != 0) && (wait_cnt_q == c_tmo_cnt);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. mem_ready is ignored in ISSUE: the memory only drops
  // ready after it has seen the new address, so a stale ready could be high.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:  if (arb_any) state_d = c_st_issue;
      c_st_issue: state_d = c_st_wait;
      c_st_wait:  if (mem_ready_i || tmo_hit) state_d = c_st_resp;
      c_st_resp:  state_d = c_st_idle;
      default:    state_d = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next values. mem_addr and mem_wdata keep their value
  // between transactions so the memory never sees a spurious new access.
  // --------------------------------------------------------------------------
  always_comb begin
    gnt_d       = gnt_q;
    we_d        = we_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wait_cnt_d  = wait_cnt_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = '0;
    rdata1_d    = '0;
    terr_d      = terr_q;

    case (state_q)
      c_st_idle: begin
        if (arb_any) begin
          gnt_d       = arb_gnt;
          we_d        = arb_gnt ? rq1_we_i    : rq0_we_i;
          mem_we_d    = arb_gnt ? rq1_we_i    : rq0_we_i;
          mem_addr_d  = arb_gnt ? rq1_addr_i  : rq0_addr_i;
          mem_wdata_d = arb_gnt ? rq1_wdata_i : rq0_wdata_i;
          wait_cnt_d  = '0;
        end
      end
      c_st_wait: begin
        if (mem_ready_i) begin
          {ack1_d, ack0_d} = gnt_q ? 2'b10 : 2'b01;
          // Writes complete with zero read data
          if (gnt_q) begin
            rdata1_d = we_q ? '0 : mem_rdata_i;
          end else begin
            rdata0_d = we_q ? '0 : mem_rdata_i;
          end
        end else if (tmo_hit) begin
          // Forced completion: ack with zero data and flag the error
          {ack1_d, ack0_d} = gnt_q ? 2'b10 : 2'b01;
          terr_d           = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + c_cw'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wait_cnt_q  <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      terr_q      <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      terr_q      <= terr_d;
    end
  end

  assign rq0_ack_o     = ack0_q;
  assign rq0_rdata_o   = rdata0_q;
  assign rq1_ack_o     = ack1_q;
  assign rq1_rdata_o   = rdata1_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign timeout_err_o = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_arbiter
//  Purpose  : Self-checking bench for data_mem_arbiter. A transaction-level
//             timeline model predicts grant order, ack cycle, read data and
//             memory command for every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_arbiter;

  localparam int TMO = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rv    = 2'b00;
  logic [1:0]  rwe   = 2'b00;
  logic [31:0] raddr  [2];
  logic [31:0] rwdata [2];
  logic        mem_ready = 1'b0;

  wire  [1:0]  ack;
  wire  [31:0] rd0, rd1;
  wire         mem_we;
  wire  [31:0] mem_addr, mem_wdata;
  wire         terr;

  // Memory behaviour: write commits on the edge that ends the we cycle
  logic [31:0] mem [0:1023] = '{default: 32'h0};
  wire  [31:0] mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq0_valid_i(rv[0]), .rq0_we_i(rwe[0]), .rq0_addr_i(raddr[0]), .rq0_wdata_i(rwdata[0]),
    .rq0_ack_o(ack[0]), .rq0_rdata_o(rd0),
    .rq1_valid_i(rv[1]), .rq1_we_i(rwe[1]), .rq1_addr_i(raddr[1]), .rq1_wdata_i(rwdata[1]),
    .rq1_ack_o(ack[1]), .rq1_rdata_o(rd1),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready), .timeout_err_o(terr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model (timeline of the single outstanding transaction)
  logic [31:0] ref_mem [0:1023];
  logic        m_busy = 1'b0, m_who = 1'b0, m_we = 1'b0, m_tmo = 1'b0;
  logic        m_last = 1'b1, m_terr = 1'b0;
  int          m_g = 0, m_r = 0, m_D = 0, next_ok = 0;
  logic [31:0] m_exp_rd = '0, m_addr_out = '0, m_wdata_out = '0;
  logic [1:0]  sv = 2'b00;

  // Requester bookkeeping / stimulus controls
  logic [1:0]  pend = 2'b00, first = 2'b00;
  int          raise_cyc [2], ack_cyc [2], ack_cnt [2];
  logic [31:0] ack_rd [2];
  int          raise_total = 0;
  int          fixed_d = 0, p_req = 0;
  logic        auto_req = 1'b0, fix_addr = 1'b0, rand_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic raise(input int n, input logic we, input logic [31:0] a, input logic [31:0] d);
    rv[n] = 1'b1; rwe[n] = we; raddr[n] = a; rwdata[n] = d;
    pend[n] = 1'b1; first[n] = 1'b1; raise_total++;
  endtask

  task automatic drive_neg();
    if (auto_req) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && ($urandom_range(99) < p_req))
          raise(n, rand_we ? 1'($urandom_range(1)) : 1'b0,
                fix_addr ? 32'(n * 4) : (32'($urandom_range(15)) << 2), $urandom());
      end
    end
    // Memory answers D cycles into the wait phase and holds ready until done
    mem_ready = m_busy && (cyc >= m_g + 1 + m_D) && (cyc < m_r);
  endtask

  task automatic model_step();
    logic [1:0] e_ack;
    if (!m_busy && cyc >= next_ok && sv != 2'b00) begin
      m_who       = (sv == 2'b11) ? ~m_last : ~sv[0];
      m_last      = m_who;
      m_busy      = 1'b1;
      m_g         = cyc;
      m_we        = rwe[m_who];
      m_addr_out  = raddr[m_who];
      m_wdata_out = rwdata[m_who];
      m_D         = (fixed_d >= 0) ? fixed_d : int'($urandom_range(9));
      m_tmo       = (m_D > TMO);
      m_r         = cyc + 2 + (m_tmo ? TMO : m_D);
      m_exp_rd    = (m_we || m_tmo) ? 32'h0 : ref_mem[m_addr_out[11:2]];
      if (m_we) ref_mem[m_addr_out[11:2]] = m_wdata_out;
    end
    e_ack = 2'b00;
    if (m_busy && cyc == m_r) begin
      e_ack = m_who ? 2'b10 : 2'b01;
      if (m_tmo) m_terr = 1'b1;
    end
    chk("ack", 32'(ack), 32'(e_ack));
    chk("rq0_rdata", rd0, e_ack[0] ? m_exp_rd : 32'h0);
    chk("rq1_rdata", rd1, e_ack[1] ? m_exp_rd : 32'h0);
    chk("mem_we", 32'(mem_we), 32'(m_busy && cyc == m_g && m_we));
    chk("mem_addr", mem_addr, m_addr_out);
    chk("mem_wdata", mem_wdata, m_wdata_out);
    chk("timeout_err", 32'(terr), 32'(m_terr));
    for (int n = 0; n < 2; n++) begin
      if (ack[n] === 1'b1) begin
        rv[n] = 1'b0; pend[n] = 1'b0; ack_cnt[n]++; ack_cyc[n] = cyc;
        ack_rd[n] = (n == 1) ? rd1 : rd0;
      end
    end
    if (m_busy && cyc == m_r) begin
      m_busy  = 1'b0;
      next_ok = cyc + 2;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    drive_neg();
    for (int n = 0; n < 2; n++) begin
      if (rv[n] && first[n]) begin raise_cyc[n] = cyc; first[n] = 1'b0; end
    end
    sv = rv;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic run_idle(input int max);
    int k = 0;
    while ((m_busy || pend != 2'b00) && k < max) begin
      tick();
      k++;
    end
    if (m_busy || pend != 2'b00) chk("idle_bound", 32'({m_busy, pend}), 32'h0);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'h0);
    chk({tag, "_rd0"}, rd0, 32'h0);
    chk({tag, "_rd1"}, rd1, 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_terr"}, 32'(terr), 32'h0);
  endtask

  initial begin
    int c0, c1, d0, d1, rt, at;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    for (int n = 0; n < 2; n++) begin
      raddr[n] = '0; rwdata[n] = '0; raise_cyc[n] = 0; ack_cyc[n] = 0; ack_cnt[n] = 0; ack_rd[n] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n   = 1'b1;
    next_ok = cyc + 1;

    // Simultaneous reads: rq0 wins the first tie, then strict alternation
    fixed_d = 0;
    raise(0, 1'b0, 32'h0, 32'h0);
    raise(1, 1'b0, 32'h4, 32'h0);
    run_idle(40);
    chk("tie_rq0_first", 32'(ack_cyc[0] < ack_cyc[1]), 32'h1);
    c0 = ack_cnt[0]; c1 = ack_cnt[1];
    auto_req = 1'b1; p_req = 100; fix_addr = 1'b1; rand_we = 1'b0;
    repeat (40) tick();
    auto_req = 1'b0;
    run_idle(40);
    d0 = ack_cnt[0] - c0; d1 = ack_cnt[1] - c1;
    chk("fair_alternation", 32'((d0 - d1 <= 1) && (d1 - d0 <= 1) && (d0 > 3)), 32'h1);

    // Write then read back with zero memory delay
    fixed_d = 0;
    raise(0, 1'b1, 32'h10, 32'hDEADBEEF);
    run_idle(20);
    chk("wr_latency", 32'(ack_cyc[0] - raise_cyc[0]), 32'd3);
    raise(0, 1'b0, 32'h10, 32'h0);
    run_idle(20);
    chk("rd_latency", 32'(ack_cyc[0] - raise_cyc[0]), 32'd3);
    chk("rd_data", ack_rd[0], 32'hDEADBEEF);

    // Slow memory, D=5
    fixed_d = 5;
    raise(1, 1'b0, 32'h10, 32'h0);
    run_idle(30);
    chk("d5_latency", 32'(ack_cyc[1] - raise_cyc[1]), 32'd8);
    chk("d5_data", ack_rd[1], 32'hDEADBEEF);

    // rq1 withdraws valid while waiting: one ack, no regrant
    fixed_d = 4;
    c1 = ack_cnt[1];
    raise(1, 1'b0, 32'h10, 32'h0);
    tick(); tick();
    rv[1] = 1'b0;
    run_idle(30);
    repeat (6) tick();
    chk("drop_ack_once", 32'(ack_cnt[1] - c1), 32'h1);

    // Memory never ready: forced completion after TIMEOUT wait cycles
    fixed_d = 100;
    raise(0, 1'b0, 32'h10, 32'h0);
    run_idle(40);
    chk("tmo_latency", 32'(ack_cyc[0] - raise_cyc[0]), 32'd11);
    chk("tmo_rdata", ack_rd[0], 32'h0);
    repeat (5) tick();
    chk("tmo_sticky", 32'(terr), 32'h1);

    // Asynchronous reset in the middle of a wait
    fixed_d = 6;
    raise(1, 1'b0, 32'h10, 32'h0);
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    rv = 2'b00; pend = 2'b00; mem_ready = 1'b0;
    m_busy = 1'b0; m_last = 1'b1; m_terr = 1'b0; m_addr_out = '0; m_wdata_out = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    next_ok = cyc + 1;
    fixed_d = 2;
    raise(1, 1'b0, 32'h10, 32'h0);
    run_idle(30);
    chk("post_rst_latency", 32'(ack_cyc[1] - raise_cyc[1]), 32'd5);
    chk("post_rst_data", ack_rd[1], 32'hDEADBEEF);

    // Randomized traffic: random direction, address, data and memory delay
    fixed_d = -1; p_req = 30; fix_addr = 1'b0; rand_we = 1'b1; auto_req = 1'b1;
    rt = raise_total; at = ack_cnt[0] + ack_cnt[1];
    repeat (500) tick();
    auto_req = 1'b0;
    run_idle(60);
    chk("rand_all_acked", 32'(ack_cnt[0] + ack_cnt[1] - at), 32'(raise_total - rt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
